// File: rtl/dma_pkg.sv
// Shared encodings and constants for the DMA transmit framer.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR0   = 3'd1,
    ST_HDR1   = 3'd2,
    ST_PAY_HI = 3'd3,
    ST_PAY_LO = 3'd4,
    ST_TRAIL  = 3'd5
  } state_t;

  localparam logic [31:0] HDR_MAGIC0   = 32'hDEADBEEF;
  localparam logic [31:0] HDR_MAGIC1   = 32'hFFFFFFFF;
  localparam logic [31:0] TRAILER_WORD = 32'h0000_0000;
  localparam logic [3:0]  TKEEP_ALL    = 4'hF;

endpackage

// File: rtl/sync_fifo64.sv
// 64-bit single-clock FWFT FIFO. Besides the head it exposes the upper half of
// the entry behind the head, so the framer can preload the next payload beat
// in the same cycle it pops.
module sync_fifo64 #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  pl_clk,
  input  logic                  nreset,
  input  logic                  push,
  input  logic [63:0]           wr_data,
  input  logic                  pop,
  output logic [63:0]           head,
  output logic [31:0]           next_hi,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [63:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_ptr_p1;
  logic                  do_push, do_pop;

  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign rd_ptr_p1 = rd_ptr + DEPTH_LOG2'(1);
  assign head      = mem[rd_ptr];
  assign next_hi   = mem[rd_ptr_p1][63:32];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge pl_clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge pl_clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr_p1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dma_tx_framer.sv
// Packs buffered 64-bit records into AXI-Stream frames:
// DEADBEEF, FFFFFFFF, {hi,lo} per record, then a zero trailer with tlast.
// Stream outputs are registered and preloaded with the next beat on each
// handshake so tvalid never gaps inside a frame.
module dma_tx_framer
  import dma_pkg::*;
#(
  parameter int DEPTH_LOG2    = 4,
  parameter int FRAME_ENTRIES = 8,
  parameter int TIMEOUT       = 1024
) (
  input  logic        pl_clk,
  input  logic        nreset,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [31:0] m_tdata,
  output logic [3:0]  m_tkeep,
  output logic        m_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [7:0]  led
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam int TW = $clog2(TIMEOUT);

  state_t          state, state_nxt;
  logic [CW-1:0]   n, n_nxt;
  logic [TW-1:0]   tcnt, tcnt_nxt;
  logic            flush_pend, flush_pend_nxt;
  logic [31:0]     tdata_nxt;
  logic            tlast_nxt, tvalid_nxt;
  logic            pop, fc_inc, hs, launch, partial;

  logic [63:0]     head;
  logic [31:0]     next_hi;
  logic [CW-1:0]   count;
  logic            fifo_full, fifo_empty;

  sync_fifo64 #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .pl_clk  (pl_clk),
    .nreset  (nreset),
    .push    (in_valid && in_ready),
    .wr_data (in_data),
    .pop     (pop),
    .head    (head),
    .next_hi (next_hi),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign m_tkeep  = TKEEP_ALL;
  assign busy     = (state != ST_IDLE);
  assign hs       = m_tvalid && m_tready;
  assign partial  = (count != '0) && (count < CW'(FRAME_ENTRIES));
  assign led      = {state[2:0], flush_pend, in_ready, fifo_empty, fifo_full, m_tvalid};

  // Next state, next output beat, launch decision and frame bookkeeping.
  always_comb begin
    state_nxt      = state;
    n_nxt          = n;
    tcnt_nxt       = '0;
    flush_pend_nxt = flush_pend | (flush && (state != ST_IDLE));
    tdata_nxt      = m_tdata;
    tlast_nxt      = m_tlast;
    tvalid_nxt     = m_tvalid;
    pop            = 1'b0;
    fc_inc         = 1'b0;
    launch         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (partial) tcnt_nxt = tcnt + TW'(1);
        launch = (count >= CW'(FRAME_ENTRIES)) || (tcnt == TW'(TIMEOUT - 1)) ||
                 ((flush || flush_pend) && (count != '0));
        if (launch) begin
          n_nxt          = (count >= CW'(FRAME_ENTRIES)) ? CW'(FRAME_ENTRIES) : count;
          flush_pend_nxt = 1'b0;
          tcnt_nxt       = '0;
          state_nxt      = ST_HDR0;
          tdata_nxt      = HDR_MAGIC0;
          tlast_nxt      = 1'b0;
          tvalid_nxt     = 1'b1;
        end
      end
      ST_HDR0: if (hs) begin
        state_nxt = ST_HDR1;
        tdata_nxt = HDR_MAGIC1;
      end
      ST_HDR1: if (hs) begin
        state_nxt = ST_PAY_HI;
        tdata_nxt = head[63:32];
      end
      ST_PAY_HI: if (hs) begin
        state_nxt = ST_PAY_LO;
        tdata_nxt = head[31:0];
      end
      ST_PAY_LO: if (hs) begin
        pop   = 1'b1;
        n_nxt = n - CW'(1);
        if (n != CW'(1)) begin
          // head is being popped this cycle, so the entry behind it is next
          state_nxt = ST_PAY_HI;
          tdata_nxt = next_hi;
        end else begin
          state_nxt = ST_TRAIL;
          tdata_nxt = TRAILER_WORD;
          tlast_nxt = 1'b1;
        end
      end
      ST_TRAIL: if (hs) begin
        fc_inc     = 1'b1;
        state_nxt  = ST_IDLE;
        tdata_nxt  = '0;
        tlast_nxt  = 1'b0;
        tvalid_nxt = 1'b0;
      end
      default: begin
        state_nxt  = ST_IDLE;
        tdata_nxt  = '0;
        tlast_nxt  = 1'b0;
        tvalid_nxt = 1'b0;
      end
    endcase
  end

  // State register, counters and registered stream outputs.
  always_ff @(posedge pl_clk or negedge nreset) begin
    if (!nreset) begin
      state       <= ST_IDLE;
      n           <= '0;
      tcnt        <= '0;
      flush_pend  <= 1'b0;
      m_tdata     <= '0;
      m_tlast     <= 1'b0;
      m_tvalid    <= 1'b0;
      frame_count <= '0;
    end else begin
      state      <= state_nxt;
      n          <= n_nxt;
      tcnt       <= tcnt_nxt;
      flush_pend <= flush_pend_nxt;
      m_tdata    <= tdata_nxt;
      m_tlast    <= tlast_nxt;
      m_tvalid   <= tvalid_nxt;
      if (fc_inc) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_dma_tx_framer.sv
// Scoreboard bench for dma_tx_framer: expected beats are queued as records are
// driven and a negedge monitor compares every handshake, tvalid gaps and stalls.
module tb_dma_tx_framer;

  localparam int TMO = 32;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic        pl_clk = 1'b0;
  logic        nreset = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        busy;
  logic [15:0] frame_count;
  logic [7:0]  led;

  int checks = 0;
  int failures = 0;
  int exp_fc = 0;

  beat_t       exp_q[$];
  logic [63:0] rec_q[$];

  bit          mon_en = 1'b0;
  bit          in_frame = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  beat_t       mon_b;

  always #5 pl_clk = ~pl_clk;

  dma_tx_framer #(.DEPTH_LOG2(4), .FRAME_ENTRIES(8), .TIMEOUT(TMO)) dut (
    .pl_clk(pl_clk), .nreset(nreset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready), .busy(busy),
    .frame_count(frame_count), .led(led)
  );

  // Stream monitor: scoreboard compare on handshake, no gaps, stable on stall.
  always @(negedge pl_clk) begin
    if (mon_en) begin
      if (in_frame) begin
        checks++;
        if (!m_tvalid) begin
          failures++;
          $display("FAIL tvalid_gap got tvalid=%b want 1", m_tvalid);
        end
      end
      if (prev_stall) begin
        checks++;
        if (m_tdata !== prev_data || m_tlast !== prev_last) begin
          failures++;
          $display("FAIL stall_hold got %h/%b want %h/%b", m_tdata, m_tlast, prev_data, prev_last);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL beat_unexpected got %h last=%b want none", m_tdata, m_tlast);
        end else begin
          mon_b = exp_q.pop_front();
          if (m_tdata !== mon_b.d || m_tlast !== mon_b.l) begin
            failures++;
            $display("FAIL beat got %h last=%b want %h last=%b", m_tdata, m_tlast, mon_b.d, mon_b.l);
          end
        end
        in_frame = !m_tlast;
      end else if (m_tvalid) begin
        in_frame = 1'b1;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  // Pop n records from the model and queue the beats of one frame.
  task automatic expect_frame(input int n);
    logic [63:0] r;
    exp_q.push_back('{32'hDEADBEEF, 1'b0});
    exp_q.push_back('{32'hFFFFFFFF, 1'b0});
    for (int i = 0; i < n; i++) begin
      r = rec_q.pop_front();
      exp_q.push_back('{r[63:32], 1'b0});
      exp_q.push_back('{r[31:0], 1'b0});
    end
    exp_q.push_back('{32'h0, 1'b1});
  endtask

  task automatic push(input logic [63:0] d);
    bit ok = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge pl_clk);
      ok = in_ready;
      @(posedge pl_clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL push_timeout got in_ready=0 want 1");
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge pl_clk); #1;
    flush = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge pl_clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got %0d beats left want 0", exp_q.size());
    end
    repeat (2) @(posedge pl_clk);
    #1;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (3) @(posedge pl_clk);
    #1 nreset = 1'b1;
    @(negedge pl_clk);
    checks++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 32'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b l=%b d=%h b=%b want 0", m_tvalid, m_tlast, m_tdata, busy);
    end
    checks++;
    if (frame_count !== 16'd0 || in_ready !== 1'b1 || m_tkeep !== 4'hF) begin
      failures++;
      $display("FAIL reset_misc got fc=%0d rdy=%b keep=%h want 0/1/f", frame_count, in_ready, m_tkeep);
    end
    checks++;
    if (led !== 8'h0C) begin
      failures++;
      $display("FAIL reset_led got %h want 0c", led);
    end
    @(posedge pl_clk); #1;
    mon_en = 1'b1;
  endtask

  task automatic test_full_frame();
    for (int i = 0; i < 8; i++) rec_q.push_back({32'(2*i+1), 32'(2*i+2)});
    expect_frame(8);
    for (int i = 0; i < 8; i++) push({32'(2*i+1), 32'(2*i+2)});
    drain(200);
    exp_fc++;
    checks++;
    if (frame_count !== 16'(exp_fc)) begin
      failures++;
      $display("FAIL full_frame_count got %0d want %0d", frame_count, exp_fc);
    end
  endtask

  task automatic test_timeout();
    int cyc = 0;
    for (int i = 0; i < 3; i++) rec_q.push_back({32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)});
    expect_frame(3);
    for (int i = 0; i < 3; i++) push({32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)});
    for (int i = 0; i < TMO + 20; i++) begin
      @(negedge pl_clk);
      cyc++;
      if (m_tvalid) break;
    end
    checks++;
    if (!m_tvalid || cyc < TMO - 2 || cyc > TMO + 1) begin
      failures++;
      $display("FAIL timeout_launch got %0d cycles want %0d..%0d", cyc, TMO - 2, TMO + 1);
    end
    @(posedge pl_clk); #1;
    drain(100);
    exp_fc++;
    checks++;
    if (frame_count !== 16'(exp_fc)) begin
      failures++;
      $display("FAIL timeout_count got %0d want %0d", frame_count, exp_fc);
    end
  endtask

  task automatic test_flush();
    rec_q.push_back(64'h1111_2222_3333_4444);
    rec_q.push_back(64'h5555_6666_7777_8888);
    expect_frame(2);
    push(64'h1111_2222_3333_4444);
    push(64'h5555_6666_7777_8888);
    flush = 1'b1;
    @(negedge pl_clk);
    checks++;
    if (m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL flush_early got tvalid=%b want 0", m_tvalid);
    end
    @(posedge pl_clk); #1;
    flush = 1'b0;
    @(negedge pl_clk);
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL flush_launch got v=%b d=%h want 1/deadbeef", m_tvalid, m_tdata);
    end
    @(posedge pl_clk); #1;
    drain(50);
    exp_fc++;
    // flush with nothing buffered must not start a frame
    pulse_flush();
    for (int i = 0; i < 20; i++) begin
      @(negedge pl_clk);
      checks++;
      if (m_tvalid !== 1'b0 || busy !== 1'b0 || led[4] !== 1'b0) begin
        failures++;
        $display("FAIL empty_flush got v=%b busy=%b pend=%b want 0", m_tvalid, busy, led[4]);
      end
    end
    @(posedge pl_clk); #1;
    checks++;
    if (frame_count !== 16'(exp_fc)) begin
      failures++;
      $display("FAIL flush_count got %0d want %0d", frame_count, exp_fc);
    end
  endtask

  task automatic test_random_ready();
    for (int i = 0; i < 8; i++) rec_q.push_back({32'(2*i+1), 32'(2*i+2)});
    expect_frame(8);
    fork
      for (int i = 0; i < 8; i++) push({32'(2*i+1), 32'(2*i+2)});
      for (int i = 0; i < 400 && (exp_q.size() != 0 || i < 12); i++) begin
        @(posedge pl_clk); #1;
        m_tready = 1'($urandom_range(0, 1));
      end
    join
    m_tready = 1'b1;
    drain(100);
    exp_fc++;
    checks++;
    if (frame_count !== 16'(exp_fc)) begin
      failures++;
      $display("FAIL random_count got %0d want %0d", frame_count, exp_fc);
    end
  endtask

  task automatic test_fill();
    logic [4:0] c0;
    bit         seen = 1'b0;
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) rec_q.push_back({32'hC000_0000 + 32'(i), 32'hD000_0000 + 32'(i)});
    rec_q.push_back(64'hFEED_F00D_CAFE_0001);
    expect_frame(8);
    expect_frame(8);
    expect_frame(1);
    for (int i = 0; i < 16; i++) push({32'hC000_0000 + 32'(i), 32'hD000_0000 + 32'(i)});
    @(negedge pl_clk);
    checks++;
    if (in_ready !== 1'b0 || led[1] !== 1'b1 || m_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL fill_full got rdy=%b full=%b v=%b want 0/1/1", in_ready, led[1], m_tvalid);
    end
    @(posedge pl_clk); #1;
    m_tready = 1'b1;
    // push exactly when a PAY_LO pop is about to happen
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge pl_clk);
      if (led[7:5] == 3'd4 && in_ready && m_tready) seen = 1'b1;
    end
    c0 = dut.u_fifo.count;
    in_data  = 64'hFEED_F00D_CAFE_0001;
    in_valid = 1'b1;
    @(posedge pl_clk); #1;
    in_valid = 1'b0;
    checks++;
    if (!seen || dut.u_fifo.count !== c0) begin
      failures++;
      $display("FAIL push_pop_count got %0d want %0d (seen=%b)", dut.u_fifo.count, c0, seen);
    end
    drain(TMO + 300);
    exp_fc += 3;
    checks++;
    if (frame_count !== 16'(exp_fc)) begin
      failures++;
      $display("FAIL fill_count got %0d want %0d", frame_count, exp_fc);
    end
  endtask

  task automatic test_reset_midframe();
    bit seen = 1'b0;
    mon_en   = 1'b0;
    m_tready = 1'b1;
    push(64'h0123_4567_89AB_CDEF);
    push(64'h1);
    push(64'h2);
    pulse_flush();
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge pl_clk);
      if (led[7:5] == 3'd4) seen = 1'b1;
    end
    m_tready = 1'b0;
    #2 nreset = 1'b0;
    #1;
    checks++;
    if (!seen || m_tvalid !== 1'b0 || led[2] !== 1'b1 || busy !== 1'b0 || frame_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_abort got seen=%b v=%b empty=%b busy=%b fc=%0d want 1/0/1/0/0",
               seen, m_tvalid, led[2], busy, frame_count);
    end
    repeat (2) @(posedge pl_clk);
    #1 nreset = 1'b1;
    exp_q.delete();
    rec_q.delete();
    in_frame   = 1'b0;
    prev_stall = 1'b0;
    m_tready   = 1'b1;
    @(posedge pl_clk); #1;
    mon_en = 1'b1;
    rec_q.push_back(64'hAAAA_5555_1234_8765);
    expect_frame(1);
    push(64'hAAAA_5555_1234_8765);
    pulse_flush();
    drain(50);
    checks++;
    if (frame_count !== 16'd1) begin
      failures++;
      $display("FAIL post_reset_count got %0d want 1", frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_timeout();
    test_flush();
    test_random_ready();
    test_fill();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
